// File: rtl/div_rem_unit.sv
// rtl/div_rem_unit.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, sampled only while busy = 0
//   abort               synchronous flush, cancels the operation in flight
//   div_op[1:0]         funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   src1_value          dividend (rs1)
//   src2_value          divisor (rs2)
//   busy                high in CALC, FIX and DONE
//   done                one-cycle pulse while result is valid
//   result              quotient or remainder, held until the next result
//
// Optional macro DIV_SPECIAL_FASTPATH_EN: divide-by-zero and signed overflow
// finish in the accept cycle instead of running the full iteration.

module div_rem_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int END_IDX    = DATA_WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       div_op,
    input  logic [END_IDX:0] src1_value,
    input  logic [END_IDX:0] src2_value,
    output logic             busy,
    output logic             done,
    output logic [END_IDX:0] result
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);
    localparam logic [END_IDX:0] MIN_VAL   = {1'b1, {END_IDX{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [END_IDX:0] quo_q;       // dividend shifting out, quotient shifting in
    logic [END_IDX:0] dvsr_q;
    logic [END_IDX:0] rem_q;       // always < divisor after each step, so W bits suffice
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             div_zero_q;
    logic             ovf_q;
    logic [END_IDX:0] src1_q;

    // Operand decode in IDLE
    logic             accept;
    logic             is_signed;
    logic             src1_neg;
    logic             src2_neg;
    logic             div_zero_in;
    logic             ovf_in;
    logic             fast_take;
    logic [END_IDX:0] src1_mag;
    logic [END_IDX:0] src2_mag;

    assign accept      = (state == S_IDLE) && start && !abort;
    assign is_signed   = !div_op[0];
    assign src1_neg    = is_signed && src1_value[END_IDX];
    assign src2_neg    = is_signed && src2_value[END_IDX];
    assign div_zero_in = (src2_value == '0);
    assign ovf_in      = is_signed && (src1_value == MIN_VAL) && (src2_value == '1);
    // The magnitude of the most negative value wraps back to itself, which is
    // the correct unsigned magnitude.
    assign src1_mag    = src1_neg ? ('0 - src1_value) : src1_value;
    assign src2_mag    = src2_neg ? ('0 - src2_value) : src2_value;

`ifdef DIV_SPECIAL_FASTPATH_EN
    logic [END_IDX:0] special_res_in;
    assign fast_take = div_zero_in || ovf_in;
    always_comb begin
        special_res_in = '0;
        if (div_zero_in) begin
            special_res_in = div_op[1] ? src1_value : '1;
        end else begin
            special_res_in = div_op[1] ? '0 : MIN_VAL;
        end
    end
`else
    assign fast_take = 1'b0;
`endif

    // One restoring step: shift {rem, dividend} left and trial-subtract.
    // The extra top bit of the difference is its sign.
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;
    logic                q_bit;

    assign shifted = {rem_q, quo_q[END_IDX]};
    assign diff    = shifted - {1'b0, dvsr_q};
    assign q_bit   = !diff[DATA_WIDTH];

    // Sign fix-up and special-case overrides
    logic [END_IDX:0] quo_fix;
    logic [END_IDX:0] rem_fix;
    logic [END_IDX:0] fix_res;

    assign quo_fix = neg_q_q ? ('0 - quo_q) : quo_q;
    assign rem_fix = neg_r_q ? ('0 - rem_q) : rem_q;

    always_comb begin
        fix_res = op_q[1] ? rem_fix : quo_fix;
        if (div_zero_q) begin
            fix_res = op_q[1] ? src1_q : '1;
        end else if (ovf_q) begin
            fix_res = op_q[1] ? '0 : MIN_VAL;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = fast_take ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == LAST_ITER) begin
                    next_state = S_FIX;
                end
            end
            S_FIX:   next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (abort) begin
            next_state = S_IDLE;
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q      <= '0;
            dvsr_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            src1_q     <= '0;
            result     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        quo_q      <= src1_mag;
                        dvsr_q     <= src2_mag;
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        op_q       <= div_op;
                        neg_q_q    <= src1_neg ^ src2_neg;
                        neg_r_q    <= src1_neg;
                        div_zero_q <= div_zero_in;
                        ovf_q      <= ovf_in;
                        src1_q     <= src1_value;
`ifdef DIV_SPECIAL_FASTPATH_EN
                        if (fast_take) begin
                            result <= special_res_in;
                        end
`endif
                    end
                end
                S_CALC: begin
                    if (!abort) begin
                        rem_q <= q_bit ? diff[END_IDX:0] : shifted[END_IDX:0];
                        quo_q <= {quo_q[END_IDX-1:0], q_bit};
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (!abort) begin
                        result <= fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/div_rem_unit.md
# div_rem_unit

Multi-cycle RV32M divide/remainder unit for DIV, DIVU, REM and REMU. It sits beside the combinational ALU operators (adder, shifters, logic ops, MULHSU multiplier) in the execute stage. It takes the same `src1_value`/`src2_value` operands and returns a registered result to the execute-stage result mux through a start/busy/done handshake. The core is a radix-2 restoring divider producing one quotient bit per clock, with RISC-V special-case handling.

## Interface
- `DATA_WIDTH`, 32: operand and result width.
- `END_IDX`, `DATA_WIDTH-1`: MSB index.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request; sampled only while `busy`=0.
- `abort`  in  1  synchronous flush (pipeline kill); cancels the operation in flight.
- `div_op`  in  2  `funct3[1:0]`: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `src1_value`  in  DATA_WIDTH  dividend (rs1).
- `src2_value`  in  DATA_WIDTH  divisor (rs2).
- `busy`  out  1  high in CALC, FIX and DONE.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  DATA_WIDTH  quotient or remainder; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: when `start`=1 and `abort`=0, latch the operands and `div_op`.
  - Signed ops (DIV, REM): store magnitudes, record `neg_q` = sign1 XOR sign2 and `neg_r` = sign1.
  - Unsigned ops: store operands unmodified, `neg_q` = `neg_r` = 0.
  - Clear the DATA_WIDTH+1-bit partial remainder and the iteration counter, then go to CALC.
- CALC: each cycle, shift the {remainder, dividend} pair left one bit and trial-subtract the divisor.
  - If the difference is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Runs exactly DATA_WIDTH iterations, then goes to FIX.
- FIX: select the quotient (DIV/DIVU) or remainder (REM/REMU).
  - Two's-complement the quotient if `neg_q`, the remainder if `neg_r`.
  - Apply the special-case overrides below, register into `result`, go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE unconditionally.
- Divide by zero: quotient = all ones for both DIV and DIVU; remainder = `src1_value` unmodified.
- Signed overflow (`src1`=0x80000000, `src2`=0xFFFFFFFF, DIV/REM only): quotient = 0x80000000, remainder = 0.
- All arithmetic is modulo 2^DATA_WIDTH. The magnitude of 0x80000000 is 0x80000000 taken as unsigned.
- `start` while `busy`=1 is ignored; nothing is queued.
- `abort`, any state: next state is IDLE, no `done` pulse, `result` unchanged. `abort` takes priority over a simultaneous `start`.
- Async reset at any point: state IDLE, `busy`=0, `done`=0, `result`=0, all internal registers 0. No partial result is produced.

## Timing
- Start accepted at edge E0.
- Normal path: FIX at E0+DATA_WIDTH, `done` high between E0+DATA_WIDTH+1 and E0+DATA_WIDTH+2 (32-bit: `done` after edge 33).
- `busy` rises after E0 and falls with `done`. A new `start` can be accepted at the edge that ends `done`, giving DATA_WIDTH+2 cycles per operation back to back.
- `result` changes only at the FIX→DONE edge (or the fast-path edge). It is stable while `done`=1 and afterwards.
- Operand inputs need to be valid only at E0.

## Configuration
- `DIV_SPECIAL_FASTPATH_EN` defined:
  - Divide-by-zero and signed overflow are detected combinationally in IDLE.
  - At E0 the special result is written and the unit goes straight to DONE; `done` is high between E0 and E0+1.
- Not defined:
  - All operations take the CALC path with normal latency.
  - FIX applies the overrides; results are bit-identical to the defined case.

## Test plan
- DIV -7/2 (0xFFFFFFF9, 2) → `result`=0xFFFFFFFD, `done` one cycle after edge 33, `busy` high edges 1–34.
- REM -7/2 → 0xFFFFFFFF; REMU 0xFFFFFFF9 % 2 → 0x00000001; DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF.
- DIVU 100/0 → 0xFFFFFFFF; REM 100/0 → 100; DIV -5/0 → 0xFFFFFFFF. Latency is 0 extra cycles with the macro, 33 without.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0; DIVU of the same operands → 0x00000000.
- `start` pulsed at CALC cycle 5 → ignored, first result unchanged. `abort` at CALC cycle 10 → `busy` low after the next edge, no `done`, `result` holds the previous value. A following DIV 100/7 → 14.
- `rst_n` low mid-CALC → `busy`, `done` and `result` go to 0 immediately, without a clock. After release, REMU 100/7 → 2.
